nip_window_buffer: RTL and testbench

//  Parametrised KxK neighbourhood window generator for the NIP pixel pipeline.

---
 rtl/nip_window_buffer_if.sv | 47 ++++
 rtl/nip_window_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_nip_window_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/nip_window_buffer_if.sv
// ---------------------------------------------------------------------------
// nip_window_buffer_if
//   Stream bundle between the pixel-source reader, nip_window_buffer and the
//   neighbourhood operator stage. It carries the raster pixel input stream and
//   the registered KxK window output stream.
//
//   Input stream : in_valid / in_ready handshake, in_sof marks pixel (0,0)
//                  of a new frame, in_pixel is the pixel data.
//   Output stream: out_valid / out_ready handshake, out_window is the packed
//                  KxK window (element (r,c) at [(r*K+c)*DATA_W +: DATA_W]),
//                  out_col / out_row locate its bottom-right pixel.
//   frame_done   : one-cycle pulse after the last pixel of a frame is taken.
//
//   Modports
//     slave  : the window buffer itself (consumes pixels, produces windows)
//     master : the environment around it (produces pixels, consumes windows)
// ---------------------------------------------------------------------------
interface nip_window_buffer_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int K      = 3
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic [DATA_W-1:0]       in_pixel;
  logic                    out_valid;
  logic                    out_ready;
  logic [K*K*DATA_W-1:0]   out_window;
  logic [COL_W-1:0]        out_col;
  logic [ROW_W-1:0]        out_row;
  logic                    frame_done;

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_col, out_row, frame_done
  );

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_col, out_row, frame_done
  );
endinterface

// File: rtl/nip_window_buffer.sv
// ---------------------------------------------------------------------------
// nip_window_buffer
//   KxK neighbourhood window generator for the NIP pixel pipeline. A raster
//   stream of IMG_W x IMG_H pixels is accepted one pixel per cycle; K-1
//   cascaded line memories hold the previous lines, and a KxK shift register
//   forms the window. A registered window is presented for every accepted
//   pixel whose window lies completely inside the image
//   (row >= K-1 and col >= K-1), one cycle after the accept.
//
//   Ports
//     clk_in1 : pipeline clock, all logic on its rising edge
//     reset_n : asynchronous active-low reset
//     bus     : nip_window_buffer_if.slave
//               in_valid/in_ready/in_sof/in_pixel      pixel input stream
//               out_valid/out_ready/out_window/
//               out_col/out_row                        window output stream
//               frame_done                             end-of-frame pulse
//
//   The output stage is a single register with no bubble: a new pixel may be
//   taken whenever the held window is either empty or being consumed this
//   cycle, so throughput is one window per cycle under continuous flow.
// ---------------------------------------------------------------------------
module nip_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int K      = 3
) (
  input  logic                clk_in1,
  input  logic                reset_n,
  nip_window_buffer_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LINES = K - 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

  typedef logic [DATA_W-1:0] pixel_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             out_valid_q, out_valid_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic             frame_done_q, frame_done_d;
  pixel_t           win_q [K][K];
  pixel_t           win_d [K][K];

  pixel_t           line_mem [LINES][IMG_W];

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic             in_ready;
  logic             accept;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic             win_hit;
  logic             last_pix;
  pixel_t           line_rd [LINES];
  pixel_t           col_in  [K];
  logic [K*K*DATA_W-1:0] window_flat;

  // The held window can be replaced in the same edge it is consumed, so the
  // input only stalls while a window sits unread.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pix_col  = col_q;
    pix_row  = row_q;
    // Start-of-frame overrides whatever position the counters hold, which
    // is how an abandoned frame is resynchronised.
    if (bus.in_sof) begin
      pix_col = '0;
      pix_row = '0;
    end
    win_hit  = (pix_row >= ROW_FIRST) && (pix_col >= COL_FIRST);
    last_pix = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
  end

  // -------------------------------------------------------------------------
  // Position counters and end-of-frame pulse
  // -------------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
      end else begin
        col_d = pix_col + COL_W'(1);
        row_d = pix_row;
      end
      frame_done_d = last_pix;
    end
  end

  // -------------------------------------------------------------------------
  // Line memories: line 0 holds the previous line, line j the line j+1 rows
  // above the incoming pixel. Reads are asynchronous so the old contents at
  // the current column are seen before this cycle's write lands.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < LINES; j++) begin
      line_rd[j] = line_mem[j][pix_col];
    end
  end

  // NOTE: the line memories have no reset; their stale contents are harmless
  // because the first K-1 rows of every frame never produce a window, and a
  // reset term would stop them mapping onto RAM.
  always_ff @(posedge clk_in1) begin
    if (accept) begin
      line_mem[0][pix_col] <= bus.in_pixel;
      for (int j = 1; j < LINES; j++) begin
        line_mem[j][pix_col] <= line_rd[j-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // KxK shift window. Row 0 is the oldest line (top), row K-1 the incoming
  // line; the new column enters at c = K-1 and older columns move left.
  // -------------------------------------------------------------------------
  always_comb begin
    col_in[K-1] = bus.in_pixel;
    for (int r = 0; r < K - 1; r++) begin
      col_in[r] = line_rd[K-2-r];
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = col_in[r];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage. Windows straddling a line wrap or lying in the top K-1
  // rows are masked by win_hit; the shift register still advances for them
  // so that later windows are complete.
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    if (accept && win_hit) begin
      out_valid_d = 1'b1;
      out_col_d   = pix_col;
      out_row_d   = pix_row;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output packing: element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
  // -------------------------------------------------------------------------
  always_comb begin
    window_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_flat[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_window = window_flat;
  assign bus.out_col    = out_col_q;
  assign bus.out_row    = out_row_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_nip_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_nip_window_buffer
//   Directed bench for nip_window_buffer with K=3, IMG_W=5, IMG_H=4, DATA_W=8.
//   Pixels are base + row*16 + col. A negedge monitor records every window
//   handed over (out_valid && out_ready) and counts frame_done pulses; the
//   main sequence compares them against windows built from the pixel formula.
// ---------------------------------------------------------------------------
module tb_nip_window_buffer;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 4;
  localparam int K      = 3;
  localparam int WIN_W  = K * K * DATA_W;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - K + 1) * (IMG_H - K + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  nip_window_buffer_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) bus ();

  nip_window_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk_in1 (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [WIN_W-1:0] win;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } rec_t;

  rec_t rec_q[$];
  int   fd_count = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      rec_q.push_back('{win: bus.out_window, col: bus.out_col, row: bus.out_row});
    end
    if (bus.frame_done) fd_count++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix_of(input int idx, input int base);
    return DATA_W'(base + (idx / IMG_W) * 16 + (idx % IMG_W));
  endfunction

  // Expected window whose bottom-right pixel sits at (row, col).
  function automatic logic [WIN_W-1:0] exp_window(input int row, input int col, input int base);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w[(r*K+c)*DATA_W +: DATA_W] = DATA_W'(base + (row - K + 1 + r) * 16 + (col - K + 1 + c));
      end
    end
    return w;
  endfunction

  // Called at edge+1; presents one pixel and returns at edge+1 after it is taken.
  task automatic send(input int idx, input int base, input logic sof);
    int budget;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix_of(idx, base);
    bus.in_sof   = sof;
    budget       = 50;
    #1;
    while (!bus.in_ready && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (budget == 0) check("in_ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < NPIX; i++) send(i, base, i == 0);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Windows of one frame appear in raster order of their bottom-right pixel.
  task automatic verify_windows(input string tag, input int start, input int base);
    for (int i = 0; i < NWIN; i++) begin
      if (start + i < rec_q.size()) begin
        check({tag, "_row"}, rec_q[start+i].row, K - 1 + i / (IMG_W - K + 1));
        check({tag, "_col"}, rec_q[start+i].col, K - 1 + i % (IMG_W - K + 1));
        check({tag, "_win"}, rec_q[start+i].win,
              exp_window(K - 1 + i / (IMG_W - K + 1), K - 1 + i % (IMG_W - K + 1), base));
      end
    end
  endtask

  initial begin
    int n0;
    int f0;

    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;

    // ---------------- Reset state ----------------
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid",  bus.out_valid, 0);
    check("rst_out_window", bus.out_window, 0);
    check("rst_out_col",    bus.out_col, 0);
    check("rst_out_row",    bus.out_row, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_in_ready",   bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // ---------------- Order ----------------
    n0 = rec_q.size();
    f0 = fd_count;
    for (int i = 0; i < 12; i++) send(i, 0, i == 0);
    check("order_no_early_valid", bus.out_valid, 0);
    send(12, 0, 1'b0);
    check("order_first_valid", bus.out_valid, 1);
    check("order_first_win",   bus.out_window, exp_window(2, 2, 0));
    check("order_first_col",   bus.out_col, 2);
    check("order_first_row",   bus.out_row, 2);
    for (int i = 13; i < NPIX; i++) send(i, 0, 1'b0);
    check("order_frame_done_pulse", bus.frame_done, 1);
    idle_cycle();
    check("order_frame_done_clear", bus.frame_done, 0);
    check("order_valid_clear",      bus.out_valid, 0);
    check("order_win_count", rec_q.size() - n0, NWIN);
    check("order_fd_count",  fd_count - f0, 1);
    verify_windows("order", n0, 0);

    // ---------------- Backpressure ----------------
    n0 = rec_q.size();
    f0 = fd_count;
    for (int i = 0; i <= 12; i++) send(i, 0, i == 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pixel  = pix_of(13, 0);
    bus.in_sof    = 1'b0;
    repeat (5) begin
      idle_cycle();
      check("bp_in_ready",  bus.in_ready, 0);
      check("bp_held_win",  bus.out_window, exp_window(2, 2, 0));
      check("bp_held_col",  bus.out_col, 2);
    end
    bus.out_ready = 1'b1;
    send(13, 0, 1'b0);
    check("bp_resume_valid", bus.out_valid, 1);
    check("bp_resume_win",   bus.out_window, exp_window(2, 3, 0));
    check("bp_resume_col",   bus.out_col, 3);
    for (int i = 14; i < NPIX; i++) send(i, 0, 1'b0);
    idle_cycle();
    check("bp_win_count", rec_q.size() - n0, NWIN);
    check("bp_fd_count",  fd_count - f0, 1);
    verify_windows("bp", n0, 0);

    // ---------------- Resync (SOF at pixel index 7) ----------------
    n0 = rec_q.size();
    f0 = fd_count;
    for (int i = 0; i < 7; i++) send(i, 'h40, i == 0);
    send_frame(0);
    idle_cycle();
    check("resync_win_count", rec_q.size() - n0, NWIN);
    check("resync_fd_count",  fd_count - f0, 1);
    verify_windows("resync", n0, 0);

    // ---------------- Reset mid-operation ----------------
    for (int i = 0; i <= 12; i++) send(i, 'h40, i == 0);
    check("mid_pre_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  bus.out_valid, 0);
    check("mid_rst_window", bus.out_window, 0);
    check("mid_rst_col",    bus.out_col, 0);
    check("mid_rst_row",    bus.out_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    n0 = rec_q.size();
    f0 = fd_count;
    // No SOF: the frame only lines up if reset cleared the position counters.
    for (int i = 0; i < NPIX; i++) send(i, 0, 1'b0);
    idle_cycle();
    check("mid_win_count", rec_q.size() - n0, NWIN);
    check("mid_fd_count",  fd_count - f0, 1);
    verify_windows("mid", n0, 0);

    // ---------------- Back-to-back frames ----------------
    n0 = rec_q.size();
    f0 = fd_count;
    send_frame(0);
    send_frame('h80);
    idle_cycle();
    check("b2b_win_count", rec_q.size() - n0, 2 * NWIN);
    check("b2b_fd_count",  fd_count - f0, 2);
    verify_windows("b2b_f1", n0, 0);
    verify_windows("b2b_f2", n0 + NWIN, 'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
